// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ valid/ready requesters, bursts up to BURST beats.
// 1-cycle arbitration in IDLE then combinational pass-through; wfull stalls the grant in place, with ready and winc held low.
module fifo_wr_arbiter #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    localparam int IW   = $clog2(NREQ),
    localparam int CW   = $clog2(BURST + 1)
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [IW-1:0]           gnt_id,
    output logic                    busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]   gnt_q, gnt_nxt;
    logic [CW-1:0]   beat_cnt, beat_cnt_nxt;

    logic [IW-1:0]   pick;
    logic            any_valid;
    logic            gnt_valid;
    logic            gnt_last;
    logic [DSIZE-1:0] gnt_data;
    logic            accept;
    logic            release_gnt;
    logic [CW-1:0]   beat_cnt_inc;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            gnt_q    <= gnt_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Search upward from rr_ptr with wrap; the first hit in rotated order wins.
    always_comb begin
        logic [IW:0] sum;
        logic [IW-1:0] idx;
        pick      = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = idx;
            end
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q == IW'(i)) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    always_comb begin
        accept = (state == GRANT) && gnt_valid && !wfull;
        winc   = accept;
        wdata  = accept ? gnt_data : '0;
        busy   = (state == GRANT);
        gnt_id = gnt_q;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state == GRANT) && (gnt_q == IW'(i)) && !wfull;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        gnt_nxt      = gnt_q;
        beat_cnt_nxt = beat_cnt;
        beat_cnt_inc = beat_cnt + CW'(1);
        release_gnt  = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    gnt_nxt      = pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                // An abandoning requester releases even while the FIFO is full.
                release_gnt = !gnt_valid ||
                              (accept && (gnt_last || beat_cnt_inc == CW'(BURST)));
                if (release_gnt) begin
                    state_nxt    = IDLE;
                    beat_cnt_nxt = '0;
                    rr_ptr_nxt   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a rule-level round-robin/burst model.
module tb_fifo_wr_arbiter;
    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;
    localparam int IW    = 2;

    logic                  wclk = 1'b0;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [IW-1:0]         gnt_id;
    logic                  busy;

    logic [DSIZE-1:0]      rd [NREQ];

    always #5 wclk = ~wclk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = rd[i];
    end

    fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
        .gnt_id(gnt_id), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the port, beats taken in this grant, where the next search starts.
    bit              m_busy;
    int              m_gid;
    int              m_cnt;
    int              m_ptr;
    logic [NREQ-1:0] acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_gid  = 0;
        m_cnt  = 0;
        m_ptr  = 0;
        acc    = '0;
    endtask

    // Check the outputs for the current inputs, then advance the model across the next edge.
    task automatic check_cycle();
        logic [NREQ-1:0]  e_rdy;
        logic             e_winc;
        logic [DSIZE-1:0] e_wd;
        bit               found;
        e_rdy  = '0;
        e_winc = 1'b0;
        e_wd   = '0;
        if (m_busy && !wfull) begin
            e_rdy[m_gid] = 1'b1;
            e_winc       = req_valid[m_gid];
            if (e_winc) e_wd = rd[m_gid];
        end
        chk("busy",      32'(busy),      32'(m_busy));
        chk("gnt_id",    32'(gnt_id),    32'(m_gid));
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("winc",      32'(winc),      32'(e_winc));
        chk("wdata",     32'(wdata),     32'(e_wd));
        acc = e_rdy & req_valid;
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (!found && req_valid[c]) begin
                    found  = 1;
                    m_gid  = c;
                    m_busy = 1;
                    m_cnt  = 0;
                end
            end
        end else if (!req_valid[m_gid] ||
                     (e_winc && (req_last[m_gid] || m_cnt + 1 == BURST))) begin
            m_busy = 0;
            m_ptr  = (m_gid + 1) % NREQ;
            m_cnt  = 0;
        end else if (e_winc) begin
            m_cnt++;
        end
    endtask

    // Requesters keep a beat stable until accepted; they may abandon it with probability pd.
    task automatic drive(input logic [NREQ-1:0] mask, input int pv, input int pl,
                         input int pd, input int pf);
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) req_valid[i] = 1'b0;
            if (!mask[i]) begin
                req_valid[i] = 1'b0;
            end else if (req_valid[i]) begin
                if ($urandom_range(99) < pd) req_valid[i] = 1'b0;
            end else if ($urandom_range(99) < pv) begin
                req_valid[i] = 1'b1;
                rd[i]        = DSIZE'($urandom);
                req_last[i]  = ($urandom_range(99) < pl);
            end
        end
        wfull = ($urandom_range(99) < pf);
    endtask

    task automatic run(input int n, input logic [NREQ-1:0] mask, input int pv,
                       input int pl, input int pd, input int pf);
        repeat (n) begin
            #1;
            drive(mask, pv, pl, pd, pf);
            #2;
            check_cycle();
            @(posedge wclk);
        end
    endtask

    initial begin
        int guard;
        wrst_n    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        wfull     = 1'b0;
        for (int i = 0; i < NREQ; i++) rd[i] = '0;
        model_reset();

        #12;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) rd[i] = DSIZE'(8'hA0 + i);
        #1;
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_winc",   32'(winc),      32'd0);
        chk("rst_ready",  32'(req_ready), 32'd0);
        chk("rst_wdata",  32'(wdata),     32'd0);
        chk("rst_gnt_id", 32'(gnt_id),    32'd0);
        req_valid = '0;
        #5 wrst_n = 1'b1;
        @(posedge wclk);

        // Single requester streaming: bursts of BURST with a bubble between re-grants.
        run(16, 4'b0001, 100, 0, 0, 0);
        // Everyone streaming: strict 0,1,2,3 rotation.
        run(30, 4'b1111, 100, 0, 0, 0);
        // Short packets from two requesters.
        run(30, 4'b1100, 100, 50, 0, 0);
        // Stalls from wfull, including long runs of it.
        run(60, 4'b1111, 100, 20, 0, 50);
        // Fully random traffic with abandons.
        run(1500, 4'b1111, 60, 30, 5, 30);

        // Reset mid-burst on requester 1.
        guard = 0;
        while (!(m_busy && m_gid == 1 && m_cnt >= 1) && guard < 40) begin
            run(1, 4'b0010, 100, 0, 0, 0);
            guard++;
        end
        chk("midburst_reached", 32'(guard < 40), 32'd1);
        #1 wrst_n = 1'b0;
        #1;
        chk("arst_winc",  32'(winc),      32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_gnt",   32'(gnt_id),    32'd0);
        model_reset();
        req_valid = 4'b1010;
        req_last  = '0;
        rd[1]     = 8'h5A;
        rd[3]     = 8'hC3;
        wfull     = 1'b0;
        #2 wrst_n = 1'b1;
        #1 check_cycle();
        @(posedge wclk);
        #1;
        chk("post_rst_gnt",  32'(gnt_id), 32'd1);
        chk("post_rst_busy", 32'(busy),   32'd1);
        run(40, 4'b1010, 100, 30, 0, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the async FIFO write port (winc/wdata, back-pressured by wfull) among NREQ requesters.
- Each requester uses a valid/ready handshake; a grant is held for a burst of up to BURST beats or until the requester signals end-of-packet.
- Sits entirely in the write-clock domain, directly in front of async_fifo.

Parameters:
- DSIZE, 8, data width; matches the FIFO data width.
- NREQ, 4, number of requesters (2..16).
- BURST, 4, maximum beats per grant (1..256).

Ports:
- wclk  input  1  write-domain clock; all state updates on rising edge.
- wrst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NREQ  per-requester data valid.
- req_data  input  NREQ*DSIZE  packed data; requester i occupies [i*DSIZE +: DSIZE].
- req_last  input  NREQ  per-requester end-of-packet, qualified by valid&ready.
- req_ready  output  NREQ  per-requester accept, one-hot or zero.
- wfull  input  1  FIFO full flag from async_fifo.
- winc  output  1  FIFO write enable.
- wdata  output  DSIZE  FIFO write data.
- gnt_id  output  clog2(NREQ)  index of the current or last granted requester.
- busy  output  1  high while a grant is active.

Behaviour:
- Reset (wrst_n low, asynchronous):
  - state=IDLE, rr_ptr=0, beat_cnt=0, gnt_id=0.
  - busy, winc, req_ready and wdata are all 0.
- FSM states:
  - IDLE:
    - if any req_valid is set, pick the first set bit searching upward from rr_ptr with wrap-around.
    - register it into gnt_id and move to GRANT on the next edge.
    - 1-cycle arbitration latency; no transfer happens in IDLE.
  - GRANT:
    - combinational outputs:
      - req_ready[gnt_id] = !wfull
      - winc = req_valid[gnt_id] & !wfull
      - wdata = req_data[gnt_id] when winc is high, else 0.
    - All other req_ready bits are 0.
- Beat accepted = winc high at a wclk edge; beat_cnt increments on each accepted beat.
- Release: return to IDLE with rr_ptr=(gnt_id+1) mod NREQ and beat_cnt=0 when any of these holds:
  - (a) an accepted beat has req_last[gnt_id]=1;
  - (b) an accepted beat brings beat_cnt to BURST;
  - (c) req_valid[gnt_id]=0 in GRANT (requester abandons; no beat).
- After a release there is always one IDLE bubble cycle before the next grant.
- wfull high in GRANT:
  - winc=0 and req_ready=0; beat_cnt, gnt_id and state hold. There is no timeout.
  - Transfer resumes the first cycle wfull is low.
- busy = (state==GRANT).
- gnt_id holds its last value in IDLE until the next arbitration.
- req_data and req_last of non-granted requesters are ignored.
- A requester must hold req_valid, req_data and req_last stable until it is accepted. Violations are not detected.
- Reset mid-burst:
  - all state is cleared immediately;
  - the partially sent packet is not resumed;
  - the first post-reset grant searches from index 0.

Test Plan:
- Only req 0 valid continuously, BURST=4, no req_last, data 0x10..0x15 → winc beats 0x10..0x13; busy drops for 1 cycle; req 0 is re-granted; then 0x14, 0x15.
- All four requesters valid continuously with distinct data → gnt_id sequence 0,1,2,3,0; each grant exactly 4 beats; exactly 1 idle cycle between grants; FIFO receives data in that order.
- Req 2 and req 3 valid; req 2 asserts req_last on its 2nd beat → req 2 gets exactly 2 beats; after the bubble gnt_id=3; rr_ptr then points to 0.
- wfull forced high for 3 cycles after the 1st beat of a grant → winc=0 and req_ready=0 for those 3 cycles; the remaining 3 beats follow with no data loss or duplication; total beats = 4.
- Granted requester drops req_valid after 1 beat → release; next valid requester granted after the bubble; beat_cnt restarts at 0.
- wrst_n pulsed low mid-burst on req 1 → winc, req_ready and busy are 0 in the same cycle (asynchronous); after release with req 1 and req 3 valid, the first grant is req 1 (search from 0).
